// File: rtl/ifid_realign_buffer_pkg.sv
// Shared definitions for the IF/ID realign buffer: FSM state encoding,
// RVC quadrant constant, canonical NOP and the halfword size classifier.
package ifid_realign_buffer_pkg;

  typedef enum logic [1:0] {
    ST_ALIGNED  = 2'b00,
    ST_HALF_BUF = 2'b01,
    ST_FETCH_HI = 2'b10
  } state_e;

  // Halfwords whose low two bits equal this start a full 32-bit instruction
  localparam logic [1:0]  RVC_QUAD_FULL = 2'b11;
  localparam logic [31:0] NOP_INSTR     = 32'h00000013;

  function automatic logic is_compressed(input logic [15:0] hw);
    return (hw[1:0] != RVC_QUAD_FULL);
  endfunction

endpackage

// File: rtl/ifid_realign_buffer_rvc_expander.sv
// Combinational RV32C -> RV32I expander. Only instantiated when RVC_EN is
// defined. Unsupported or illegal encodings expand to the canonical NOP.
module rvc_expander
  import ifid_realign_buffer_pkg::*;
(
  input  logic [15:0] c_i,
  output logic [31:0] instr_o
);

  logic [4:0] rd_s;
  logic [4:0] rs2_s;
  logic [2:0] funct3_s;

  assign rd_s     = c_i[11:7];
  assign rs2_s    = c_i[6:2];
  assign funct3_s = c_i[15:13];

  // Map supported compressed encodings onto their 32-bit equivalents
  always_comb begin
    instr_o = NOP_INSTR;
    case (c_i[1:0])
      2'b00: begin
        if (funct3_s == 3'b010) begin
          // c.lw
          instr_o = {5'd0, c_i[5], c_i[12:10], c_i[6], 2'b00, 2'b01, c_i[9:7],
                     3'b010, 2'b01, c_i[4:2], 7'b0000011};
        end else begin
          instr_o = NOP_INSTR;
        end
      end
      2'b01: begin
        case (funct3_s)
          3'b000: instr_o = {{6{c_i[12]}}, c_i[12], c_i[6:2], rd_s, 3'b000, rd_s, 7'b0010011};
          3'b010: instr_o = {{6{c_i[12]}}, c_i[12], c_i[6:2], 5'd0, 3'b000, rd_s, 7'b0010011};
          3'b011: begin
            if ((rd_s != 5'd2) && (rd_s != 5'd0)) begin
              instr_o = {{14{c_i[12]}}, c_i[12], c_i[6:2], rd_s, 7'b0110111};
            end else begin
              instr_o = NOP_INSTR;
            end
          end
          3'b101: instr_o = {c_i[12], c_i[8], c_i[10:9], c_i[6], c_i[7], c_i[2], c_i[11],
                             c_i[5:3], c_i[12], {8{c_i[12]}}, 5'd0, 7'b1101111};
          default: instr_o = NOP_INSTR;
        endcase
      end
      2'b10: begin
        case (funct3_s)
          3'b000: instr_o = {7'd0, c_i[6:2], rd_s, 3'b001, rd_s, 7'b0010011};
          3'b010: begin
            if (rd_s != 5'd0) begin
              instr_o = {4'd0, c_i[3:2], c_i[12], c_i[6:4], 2'b00, 5'd2, 3'b010, rd_s, 7'b0000011};
            end else begin
              instr_o = NOP_INSTR;
            end
          end
          3'b100: begin
            if (c_i[12] == 1'b0) begin
              if (rs2_s == 5'd0) begin
                instr_o = {12'd0, rd_s, 3'b000, 5'd0, 7'b1100111};
              end else begin
                instr_o = {7'd0, rs2_s, 5'd0, 3'b000, rd_s, 7'b0110011};
              end
            end else begin
              if (rs2_s != 5'd0) begin
                instr_o = {7'd0, rs2_s, rd_s, 3'b000, rd_s, 7'b0110011};
              end else if (rd_s != 5'd0) begin
                instr_o = {12'd0, rd_s, 3'b000, 5'd1, 7'b1100111};
              end else begin
                instr_o = NOP_INSTR;
              end
            end
          end
          default: instr_o = NOP_INSTR;
        endcase
      end
      default: instr_o = NOP_INSTR;
    endcase
  end

endmodule

// File: rtl/ifid_realign_buffer.sv
// IF/ID realign buffer: turns a word-aligned fetch stream into one
// instruction per cycle. Compressed (16-bit) support is built only when the
// macro RVC_EN is defined; otherwise every word is a 32-bit instruction.
module ifid_realign_buffer
  import ifid_realign_buffer_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        Stall_i,
  input  logic        Flush_i,
  input  logic [31:0] Target_pc_i,
  input  logic [31:0] Instr_word_i,
  output logic [31:0] Fetch_addr_o,
  output logic [31:0] Instr_o,
  output logic [31:0] Pc_o,
  output logic        Valid_o,
  output logic        Compressed_o
);

  logic [31:0] fetch_addr_q, fetch_addr_d;
  logic [31:0] next_pc_q, next_pc_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic        compressed_q, compressed_d;

`ifdef RVC_EN
  state_e      state_q, state_d;
  logic [15:0] half_buf_q, half_buf_d;
  logic [15:0] exp_in_s;
  logic [31:0] exp_out_s;

  // Select the halfword the current state may emit as a compressed instruction
  always_comb begin
    exp_in_s = Instr_word_i[15:0];
    case (state_q)
      ST_ALIGNED:  exp_in_s = Instr_word_i[15:0];
      ST_HALF_BUF: exp_in_s = half_buf_q;
      ST_FETCH_HI: exp_in_s = Instr_word_i[31:16];
      default:     exp_in_s = Instr_word_i[15:0];
    endcase
  end

  rvc_expander u_rvc_expander (
    .c_i     (exp_in_s),
    .instr_o (exp_out_s)
  );

  // Realignment FSM next-state and output computation
  always_comb begin
    state_d      = state_q;
    half_buf_d   = half_buf_q;
    fetch_addr_d = fetch_addr_q;
    next_pc_d    = next_pc_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    valid_d      = valid_q;
    compressed_d = compressed_q;
    if (Flush_i) begin
      state_d      = Target_pc_i[1] ? ST_FETCH_HI : ST_ALIGNED;
      half_buf_d   = 16'h0000;
      fetch_addr_d = {Target_pc_i[31:2], 2'b00};
      next_pc_d    = Target_pc_i;
      instr_d      = 32'h00000000;
      valid_d      = 1'b0;
      compressed_d = 1'b0;
    end else if (!Stall_i) begin
      pc_d         = next_pc_q;
      valid_d      = 1'b1;
      compressed_d = 1'b0;
      instr_d      = Instr_word_i;
      next_pc_d    = next_pc_q + 32'd4;
      fetch_addr_d = fetch_addr_q + 32'd4;
      case (state_q)
        ST_ALIGNED: begin
          if (is_compressed(Instr_word_i[15:0])) begin
            instr_d      = exp_out_s;
            compressed_d = 1'b1;
            next_pc_d    = next_pc_q + 32'd2;
            half_buf_d   = Instr_word_i[31:16];
            state_d      = ST_HALF_BUF;
          end else begin
            state_d = ST_ALIGNED;
          end
        end
        ST_HALF_BUF: begin
          if (is_compressed(half_buf_q)) begin
            // Buffered half alone is the instruction; the fetched word waits
            instr_d      = exp_out_s;
            compressed_d = 1'b1;
            next_pc_d    = next_pc_q + 32'd2;
            fetch_addr_d = fetch_addr_q;
            state_d      = ST_ALIGNED;
          end else begin
            instr_d    = {Instr_word_i[15:0], half_buf_q};
            half_buf_d = Instr_word_i[31:16];
            state_d    = ST_HALF_BUF;
          end
        end
        ST_FETCH_HI: begin
          if (is_compressed(Instr_word_i[31:16])) begin
            instr_d      = exp_out_s;
            compressed_d = 1'b1;
            next_pc_d    = next_pc_q + 32'd2;
            state_d      = ST_ALIGNED;
          end else begin
            // Upper half starts a 32-bit instruction: nothing to emit yet
            half_buf_d = Instr_word_i[31:16];
            instr_d    = 32'h00000000;
            valid_d    = 1'b0;
            pc_d       = pc_q;
            next_pc_d  = next_pc_q;
            state_d    = ST_HALF_BUF;
          end
        end
        default: begin
          state_d      = ST_ALIGNED;
          instr_d      = 32'h00000000;
          valid_d      = 1'b0;
          pc_d         = pc_q;
          next_pc_d    = next_pc_q;
          fetch_addr_d = fetch_addr_q;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // FSM state and halfword buffer registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_ALIGNED;
      half_buf_q <= 16'h0000;
    end else begin
      state_q    <= state_d;
      half_buf_q <= half_buf_d;
    end
  end
`else
  // Word-only pipeline: one 32-bit instruction per fetched word
  always_comb begin
    fetch_addr_d = fetch_addr_q;
    next_pc_d    = next_pc_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    valid_d      = valid_q;
    compressed_d = 1'b0;
    if (Flush_i) begin
      fetch_addr_d = {Target_pc_i[31:2], 2'b00};
      next_pc_d    = {Target_pc_i[31:2], 2'b00};
      instr_d      = 32'h00000000;
      valid_d      = 1'b0;
    end else if (!Stall_i) begin
      pc_d         = next_pc_q;
      instr_d      = Instr_word_i;
      valid_d      = 1'b1;
      next_pc_d    = next_pc_q + 32'd4;
      fetch_addr_d = fetch_addr_q + 32'd4;
    end else begin
      valid_d = valid_q;
    end
  end
`endif

  // Output and fetch-pointer registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_addr_q <= 32'h00000000;
      next_pc_q    <= 32'h00000000;
      pc_q         <= 32'h00000000;
      instr_q      <= 32'h00000000;
      valid_q      <= 1'b0;
      compressed_q <= 1'b0;
    end else begin
      fetch_addr_q <= fetch_addr_d;
      next_pc_q    <= next_pc_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      valid_q      <= valid_d;
      compressed_q <= compressed_d;
    end
  end

  assign Fetch_addr_o = fetch_addr_q;
  assign Instr_o      = instr_q;
  assign Pc_o         = pc_q;
  assign Valid_o      = valid_q;
  assign Compressed_o = compressed_q;

endmodule

// File: tb/tb_ifid_realign_buffer.sv
// Directed, table-driven bench for ifid_realign_buffer. The table matching
// the build (RVC_EN defined or not) is selected at compile time.
module tb_ifid_realign_buffer;

  logic        clk_i;
  logic        rst_i;
  logic        Stall_i;
  logic        Flush_i;
  logic [31:0] Target_pc_i;
  logic [31:0] Instr_word_i;
  logic [31:0] Fetch_addr_o;
  logic [31:0] Instr_o;
  logic [31:0] Pc_o;
  logic        Valid_o;
  logic        Compressed_o;

  logic [31:0] mem [0:255];
  int tests;
  int failed;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        flush;
    logic [31:0] target;
    logic        ev;
    logic [31:0] ei;
    logic [31:0] ep;
    logic [31:0] ef;
    logic        ec;
    logic        cp;
  } vec_t;

  vec_t vecs[$];

  ifid_realign_buffer dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .Stall_i      (Stall_i),
    .Flush_i      (Flush_i),
    .Target_pc_i  (Target_pc_i),
    .Instr_word_i (Instr_word_i),
    .Fetch_addr_o (Fetch_addr_o),
    .Instr_o      (Instr_o),
    .Pc_o         (Pc_o),
    .Valid_o      (Valid_o),
    .Compressed_o (Compressed_o)
  );

  assign Instr_word_i = mem[Fetch_addr_o[9:2]];

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic add(input logic r, input logic s, input logic f, input logic [31:0] t,
                     input logic ev, input logic [31:0] ei, input logic [31:0] ep,
                     input logic [31:0] ef, input logic ec, input logic cp);
    vec_t v;
    v.rst = r; v.stall = s; v.flush = f; v.target = t;
    v.ev = ev; v.ei = ei; v.ep = ep; v.ef = ef; v.ec = ec; v.cp = cp;
    vecs.push_back(v);
  endtask

  task automatic check(input string nm, input logic ev, input logic [31:0] ei,
                       input logic [31:0] ep, input logic [31:0] ef, input logic ec,
                       input logic cp);
    tests++;
    if (Valid_o !== ev || Instr_o !== ei || (cp && Pc_o !== ep) ||
        Fetch_addr_o !== ef || Compressed_o !== ec) begin
      failed++;
      $display("FAIL %s: got v=%0b i=%h pc=%h fa=%h c=%0b, expected v=%0b i=%h pc=%h(chk=%0b) fa=%h c=%0b",
               nm, Valid_o, Instr_o, Pc_o, Fetch_addr_o, Compressed_o, ev, ei, ep, cp, ef, ec);
    end
  endtask

  task automatic step(input logic r, input logic s, input logic f, input logic [31:0] t);
    rst_i = r; Stall_i = s; Flush_i = f; Target_pc_i = t;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    tests = 0;
    failed = 0;
    rst_i = 1'b1; Stall_i = 1'b0; Flush_i = 1'b0; Target_pc_i = 32'h0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h00000003 + (32'(i) << 12);
    mem[0] = 32'h00000013;
    mem[1] = 32'h00000013;
    mem[2] = 32'h45014501;

`ifdef RVC_EN
    mem[3]  = 32'h00134501;
    mem[4]  = 32'h45010000;
    mem[64] = 32'h45010000;
    mem[65] = 32'h00300193;
    mem[66] = 32'h00931111;
    mem[67] = 32'h222200A0;
    //  rst   stl   fl    target        v     instr         pc            fetch         c     chkpc
    add(1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0, 1'b1);
    add(1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h00000013, 32'h00000000, 32'h00000004, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h00000013, 32'h00000004, 32'h00000008, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h00000513, 32'h00000008, 32'h0000000C, 1'b1, 1'b1);
    add(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h00000513, 32'h0000000A, 32'h0000000C, 1'b1, 1'b1);
    add(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h00000513, 32'h0000000C, 32'h00000010, 1'b1, 1'b1);
    add(1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h00000513, 32'h0000000C, 32'h00000010, 1'b1, 1'b1);
    add(1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h00000513, 32'h0000000C, 32'h00000010, 1'b1, 1'b1);
    add(1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h00000513, 32'h0000000C, 32'h00000010, 1'b1, 1'b1);
    add(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h00000013, 32'h0000000E, 32'h00000014, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h00000513, 32'h00000012, 32'h00000014, 1'b1, 1'b1);
    add(1'b0, 1'b1, 1'b1, 32'h102,      1'b0, 32'h00000000, 32'h00000000, 32'h00000100, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h00000513, 32'h00000102, 32'h00000104, 1'b1, 1'b1);
    add(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h00300193, 32'h00000104, 32'h00000108, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b1, 32'h10A,      1'b0, 32'h00000000, 32'h00000000, 32'h00000108, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h00000000, 32'h00000000, 32'h0000010C, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h00A00093, 32'h0000010A, 32'h00000110, 1'b0, 1'b1);
    add(1'b1, 1'b1, 1'b1, 32'h102,      1'b0, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h00000013, 32'h00000000, 32'h00000004, 1'b0, 1'b1);
`else
    mem[3]   = 32'h00A00093;
    mem[64]  = 32'h00200113;
    mem[65]  = 32'h00300193;
    mem[255] = 32'h00400213;
    //  rst   stl   fl    target        v     instr         pc            fetch         c     chkpc
    add(1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0, 1'b1);
    add(1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h00000013, 32'h00000000, 32'h00000004, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h00000013, 32'h00000004, 32'h00000008, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h45014501, 32'h00000008, 32'h0000000C, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h45014501, 32'h00000008, 32'h0000000C, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h45014501, 32'h00000008, 32'h0000000C, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h00A00093, 32'h0000000C, 32'h00000010, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b1, 32'h102,      1'b0, 32'h00000000, 32'h00000000, 32'h00000100, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h00200113, 32'h00000100, 32'h00000104, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h00300193, 32'h00000104, 32'h00000108, 1'b0, 1'b1);
    add(1'b1, 1'b1, 1'b1, 32'h102,      1'b0, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h00000013, 32'h00000000, 32'h00000004, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b1, 32'hFFFFFFFC, 1'b0, 32'h00000000, 32'h00000000, 32'hFFFFFFFC, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h00400213, 32'hFFFFFFFC, 32'h00000000, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h00000013, 32'h00000000, 32'h00000004, 1'b0, 1'b1);
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].stall, vecs[i].flush, vecs[i].target);
      check($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ei, vecs[i].ep, vecs[i].ef,
            vecs[i].ec, vecs[i].cp);
    end

    // Stall hold while the memory word under the fetch pointer changes
    mem[1] = 32'h00B00113;
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b1, 1'b0, 32'h0);
      check($sformatf("stall_hold%0d", k), 1'b1, 32'h00000013, 32'h00000000,
            32'h00000004, 1'b0, 1'b1);
    end
    step(1'b0, 1'b0, 1'b0, 32'h0);
    check("stall_release", 1'b1, 32'h00B00113, 32'h00000004, 32'h00000008, 1'b0, 1'b1);

    // Reset in the middle of a stall wins and restarts at address 0
    step(1'b1, 1'b1, 1'b0, 32'h0);
    check("reset_over_stall", 1'b0, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    check("first_after_reset", 1'b1, 32'h00000013, 32'h00000000, 32'h00000004, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
